// File: rtl/ultrasonic_scheduler_if.sv
// Bundle of the measurement-side signals of the ultrasonic scheduler.
// The master side drives the control inputs and echo lines. The slave side
// is the scheduler, which returns triggers, distances and status.
interface ultrasonic_scheduler_if #(
   parameter int NUM_SENSORS = 3
);
   logic                       enable;
   logic [7:0]                 threshold;
   logic [NUM_SENSORS-1:0]     echo;
   logic [NUM_SENSORS-1:0]     trig;
   logic [8*NUM_SENSORS-1:0]   distance;
   logic                       sample_valid;
   logic [1:0]                 sample_idx;
   logic [NUM_SENSORS-1:0]     timeout;
   logic                       too_close;

   modport master (
      output enable, threshold, echo,
      input  trig, distance, sample_valid, sample_idx, timeout, too_close
   );

   modport slave (
      input  enable, threshold, echo,
      output trig, distance, sample_valid, sample_idx, timeout, too_close
   );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for up to four ultrasonic range sensors.
// Only one sensor is triggered at a time. Its echo pulse width is converted
// to whole centimetres and latched per sensor. A quiet guard period follows
// each measurement so late reflections cannot reach the next sensor.
module ultrasonic_scheduler #(
   parameter int NUM_SENSORS    = 3,
   parameter int TRIG_CYCLES    = 500,
   parameter int CYCLES_PER_CM  = 2900,
   parameter int TIMEOUT_CYCLES = 1250000,
   parameter int GUARD_CYCLES   = 500000
) (
   input logic                   CLOCK_50,
   input logic                   reset_n,
   ultrasonic_scheduler_if.slave bus
);

   // One shared phase counter covers the trigger, wait, measure and guard phases.
   localparam int MAX_CNT = (TIMEOUT_CYCLES > GUARD_CYCLES)
                          ? ((TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES)
                          : ((GUARD_CYCLES > TRIG_CYCLES) ? GUARD_CYCLES : TRIG_CYCLES);
   localparam int CNT_W = $clog2(MAX_CNT + 1);
   localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
   localparam logic [1:0]       IDX_LAST     = 2'(NUM_SENSORS - 1);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      GUARD
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               idx_q, idx_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SUB_W-1:0]         sub_q, sub_d;
   logic [7:0]               cm_q, cm_d;
   logic [8*NUM_SENSORS-1:0] dist_q, dist_d;
   logic [NUM_SENSORS-1:0]   timeout_q, timeout_d;
   logic                     sampleValid_q, sampleValid_d;
   logic [1:0]               sampleIdx_q, sampleIdx_d;
   logic                     tooClose_q;

   logic [NUM_SENSORS-1:0]   echoMeta_q, echoSync_q, echoPrev_q;
   logic                     echoRise, echoFall;
   logic                     resultEn;
   logic [7:0]               resultCm;
   logic                     resultTimeout;
   logic                     anyClose;

   // Two-flop synchroniser on every echo line, plus a third copy for edge detection.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         echoMeta_q <= '0;
         echoSync_q <= '0;
         echoPrev_q <= '0;
      end else begin
         echoMeta_q <= bus.echo;
         echoSync_q <= echoMeta_q;
         echoPrev_q <= echoSync_q;
      end
   end

   // Only the currently scheduled sensor's edges matter; the others are ignored.
   assign echoRise = echoSync_q[idx_q] & ~echoPrev_q[idx_q];
   assign echoFall = ~echoSync_q[idx_q] & echoPrev_q[idx_q];

   // Next-state logic: phase sequencing, cm conversion and result capture.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      sub_d         = sub_q;
      cm_d          = cm_q;
      dist_d        = dist_q;
      timeout_d     = timeout_q;
      sampleValid_d = 1'b0;
      sampleIdx_d   = sampleIdx_q;
      resultEn      = 1'b0;
      resultCm      = 8'd255;
      resultTimeout = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               state_d = TRIG;
               cnt_d   = '0;
            end
         end

         TRIG: begin
            if (cnt_q == TRIG_LAST) begin
               state_d = WAIT_ECHO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_ECHO: begin
            if (echoRise) begin
               state_d = MEASURE;
               cnt_d   = '0;
               sub_d   = '0;
               cm_d    = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               resultEn = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         MEASURE: begin
            if (echoFall) begin
               resultEn      = 1'b1;
               resultCm      = cm_q;
               resultTimeout = 1'b0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               resultEn = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (sub_q == SUB_LAST) begin
                  sub_d = '0;
                  cm_d  = (cm_q == 8'd255) ? cm_q : cm_q + 8'd1;
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
         end

         GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
               state_d = bus.enable ? TRIG : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (resultEn) begin
         dist_d[8*idx_q +: 8] = resultCm;
         timeout_d[idx_q]     = resultTimeout;
         sampleValid_d        = 1'b1;
         sampleIdx_d          = idx_q;
         state_d              = GUARD;
         cnt_d                = '0;
      end
   end

   // State, counters and result registers; reset discards any partial measurement.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         idx_q         <= 2'd0;
         cnt_q         <= '0;
         sub_q         <= '0;
         cm_q          <= '0;
         dist_q        <= '1;
         timeout_q     <= '0;
         sampleValid_q <= 1'b0;
         sampleIdx_q   <= 2'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         sub_q         <= sub_d;
         cm_q          <= cm_d;
         dist_q        <= dist_d;
         timeout_q     <= timeout_d;
         sampleValid_q <= sampleValid_d;
         sampleIdx_q   <= sampleIdx_d;
      end
   end

   // Proximity compare of every slot against the live threshold.
   always_comb begin
      anyClose = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (dist_q[8*i +: 8] < bus.threshold) begin
            anyClose = 1'b1;
         end
      end
   end

   // Registered proximity flag, one clock behind slot or threshold changes.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         tooClose_q <= 1'b0;
      end else begin
         tooClose_q <= anyClose;
      end
   end

   // Trigger is a one-hot decode of the registered state, so reset drops it at once.
   assign bus.trig         = (state_q == TRIG) ? (NUM_SENSORS'(1) << idx_q) : '0;
   assign bus.distance     = dist_q;
   assign bus.timeout      = timeout_q;
   assign bus.sample_valid = sampleValid_q;
   assign bus.sample_idx   = sampleIdx_q;
   assign bus.too_close    = tooClose_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler. It runs randomised echo responses, each
// checked against a pulse-width-to-centimetre reference model.
module tb_ultrasonic_scheduler;

   localparam int NS  = 3;
   localparam int TC  = 4;
   localparam int CPC = 10;
   localparam int TO  = 3000;
   localparam int GC  = 20;

   logic CLOCK_50 = 1'b0;
   logic reset_n;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleCount  = 0;
   int multiHot    = 0;
   int lastSvCycle = 0;
   bit gapValid    = 1'b0;
   int curThr      = 0;

   int modelDist [NS];
   bit modelTo   [NS];

   ultrasonic_scheduler_if #(.NUM_SENSORS(NS)) busIf ();

   ultrasonic_scheduler #(
      .NUM_SENSORS   (NS),
      .TRIG_CYCLES   (TC),
      .CYCLES_PER_CM (CPC),
      .TIMEOUT_CYCLES(TO),
      .GUARD_CYCLES  (GC)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset_n (reset_n),
      .bus     (busIf.slave)
   );

   // Free-running 100 MHz-style bench clock.
   always #5 CLOCK_50 = ~CLOCK_50;

   // Cycle counter used for guard-gap measurements.
   always @(posedge CLOCK_50) cycleCount <= cycleCount + 1;

   // Watch for more than one trigger line high at any time.
   always @(negedge CLOCK_50) begin
      if ($countones(busIf.trig) > 1) multiHot <= multiHot + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NS; i++) begin
         modelDist[i] = 255;
         modelTo[i]   = 1'b0;
      end
   endtask

   function automatic logic [8*NS-1:0] modelDistVec();
      logic [8*NS-1:0] v;
      for (int i = 0; i < NS; i++) v[8*i +: 8] = 8'(modelDist[i]);
      return v;
   endfunction

   function automatic logic [NS-1:0] modelToVec();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = modelTo[i];
      return v;
   endfunction

   function automatic logic modelTooClose();
      logic r;
      r = 1'b0;
      for (int i = 0; i < NS; i++) if (modelDist[i] < curThr) r = 1'b1;
      return r;
   endfunction

   task automatic setThreshold(input int thr);
      curThr          = thr;
      busIf.threshold = 8'(thr);
   endtask

   // One full measurement: expect a trigger on expIdx, answer it with an echo
   // (width < 0 means the echo never rises), then check the latched result.
   task automatic applyStimulus(input int expIdx, input int delay, input int width,
                                input bit noise, input bit dropEn);
      int c;
      int trigLen;
      int gap;
      int bound;
      int trigCount;
      bit seen;
      logic [NS-1:0] e;

      c = 0;
      while (busIf.trig == '0 && c < TO + GC + 200) begin
         @(negedge CLOCK_50);
         c++;
      end
      checkOutput("trigSeen", busIf.trig != '0, 1);
      if (busIf.trig == '0) return;
      if (gapValid) begin
         gap = cycleCount - lastSvCycle;
         checkOutput("guardGap", (gap >= GC && gap <= GC + 2), 1);
      end
      checkOutput("trigIdx", busIf.trig, 64'(1) << expIdx);
      trigLen = 0;
      while (busIf.trig != '0 && trigLen < 100) begin
         trigLen++;
         @(negedge CLOCK_50);
      end
      checkOutput("trigLen", trigLen, TC);

      bound = delay + ((width > 0) ? width : 0) + TO + 100;
      seen  = 1'b0;
      c     = 0;
      while (!seen && c < bound) begin
         e = noise ? NS'($urandom) : '0;
         e[expIdx] = (width > 0 && c >= delay && c < delay + width);
         busIf.echo = e;
         if (dropEn && c == 2) busIf.enable = 1'b0;
         @(negedge CLOCK_50);
         c++;
         if (busIf.sample_valid) seen = 1'b1;
      end
      busIf.echo = '0;
      checkOutput("svSeen", seen, 1);
      if (!seen) return;

      if (width < 0 || width >= TO) begin
         modelDist[expIdx] = 255;
         modelTo[expIdx]   = 1'b1;
      end else begin
         modelDist[expIdx] = (width / CPC > 255) ? 255 : width / CPC;
         modelTo[expIdx]   = 1'b0;
      end
      if (width < 0) checkOutput("waitTimeout", (c >= TO && c <= TO + 2), 1);
      checkOutput("sampleIdx", busIf.sample_idx, expIdx);
      checkOutput("distance", busIf.distance, modelDistVec());
      checkOutput("timeout", busIf.timeout, modelToVec());
      lastSvCycle = cycleCount;
      gapValid    = 1'b1;

      @(negedge CLOCK_50);
      checkOutput("svPulse", busIf.sample_valid, 0);
      checkOutput("tooClose", busIf.too_close, modelTooClose());

      if (dropEn) begin
         trigCount = 0;
         repeat (60) begin
            @(negedge CLOCK_50);
            if (busIf.trig != '0) trigCount++;
         end
         checkOutput("idleHold", trigCount, 0);
         gapValid = 1'b0;
      end
   endtask

   // Pulse reset while sensor expIdx is mid-measurement and check the cleared state.
   task automatic resetDuringMeasure(input int expIdx);
      int c;
      c = 0;
      while (busIf.trig == '0 && c < TO + GC + 200) begin
         @(negedge CLOCK_50);
         c++;
      end
      checkOutput("rstTrigIdx", busIf.trig, 64'(1) << expIdx);
      c = 0;
      while (busIf.trig != '0 && c < 100) begin
         @(negedge CLOCK_50);
         c++;
      end
      busIf.echo = NS'(1) << expIdx;
      repeat (50) @(negedge CLOCK_50);
      reset_n = 1'b0;
      #1;
      checkOutput("rstTrig", busIf.trig, 0);
      checkOutput("rstDist", busIf.distance, {(8*NS){1'b1}});
      checkOutput("rstTimeout", busIf.timeout, 0);
      checkOutput("rstTooClose", busIf.too_close, 0);
      checkOutput("rstSv", busIf.sample_valid, 0);
      busIf.echo = '0;
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      modelReset();
      gapValid = 1'b0;
   endtask

   initial begin
      int w;
      reset_n      = 1'b0;
      busIf.enable = 1'b0;
      busIf.echo   = '0;
      setThreshold(0);
      modelReset();
      repeat (3) @(negedge CLOCK_50);
      checkOutput("resetTrig", busIf.trig, 0);
      checkOutput("resetDist", busIf.distance, {(8*NS){1'b1}});
      checkOutput("resetTimeout", busIf.timeout, 0);
      checkOutput("resetSv", busIf.sample_valid, 0);
      checkOutput("resetSidx", busIf.sample_idx, 0);
      checkOutput("resetTooClose", busIf.too_close, 0);
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      busIf.enable = 1'b1;

      applyStimulus(0, 10, 123, 1'b0, 1'b0);
      applyStimulus(1, 0, -1, 1'b0, 1'b0);
      applyStimulus(2, 15, 3150, 1'b1, 1'b0);
      applyStimulus(0, 7, 2605, 1'b1, 1'b0);
      applyStimulus(1, 20, 455, 1'b1, 1'b1);

      setThreshold(30);
      @(negedge CLOCK_50);
      checkOutput("thr30", busIf.too_close, modelTooClose());
      busIf.enable = 1'b1;

      applyStimulus(2, 12, 255, 1'b1, 1'b0);
      setThreshold(20);
      @(negedge CLOCK_50);
      checkOutput("thr20", busIf.too_close, modelTooClose());

      for (int r = 0; r < 6; r++) begin
         w = $urandom_range(20, 700);
         if (w % CPC == 0) w++;
         if (r == 5) w = -1;
         setThreshold($urandom_range(0, 60));
         applyStimulus(r % NS, $urandom_range(3, 300), w, 1'b1, 1'b0);
      end

      setThreshold(255);
      applyStimulus(0, 9, 333, 1'b1, 1'b0);
      resetDuringMeasure(1);
      applyStimulus(0, 5, 87, 1'b0, 1'b0);

      checkOutput("multiHot", multiHot, 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
